// File: rtl/hfg_window_scheduler.sv
// hfg_window_scheduler
// Steps a WIN x WIN detection window over an image in raster order. For each
// window position it enables the feature generator, waits for its verdict or a
// timeout, and then holds the enable low for a fixed gap before it moves on.
//
// Ports
//   iClk, iReset_n              clock (rising edge) and async active-low reset
//   iStart, iAbort              scan request (IDLE only) and immediate stop
//   iImg_width, iImg_height     image size in pixels, sampled at iStart
//   iStep                       window stride 1..7, sampled at iStart
//   iWin_done, iWin_face        end-of-window pulse and its face verdict
//   oRun                        level enable to the feature generator
//   oWin_x, oWin_y              top-left corner of the current window
//   oBusy                       high whenever the scheduler is not idle
//   oFace_valid                 pulse: face at oWin_x/oWin_y
//   oFace_count, oWin_count     per-scan counters (saturating / wrapping)
//   oTimeout                    sticky: a window ran out of time this scan
//   oErr, oDone                 pulses: start rejected / scan complete
module hfg_window_scheduler #(
    parameter int unsigned WIN         = 19,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 8191
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic        iAbort,
    input  logic [8:0]  iImg_width,
    input  logic [8:0]  iImg_height,
    input  logic [2:0]  iStep,
    input  logic        iWin_done,
    input  logic        iWin_face,
    output logic        oRun,
    output logic [8:0]  oWin_x,
    output logic [8:0]  oWin_y,
    output logic        oBusy,
    output logic        oFace_valid,
    output logic [7:0]  oFace_count,
    output logic [15:0] oWin_count,
    output logic        oTimeout,
    output logic        oErr,
    output logic        oDone
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_NEXT, S_DONE} state_t;

    localparam logic [9:0]  WIN10    = 10'(WIN);
    localparam logic [13:0] TMO_LAST = 14'(TIMEOUT_CYC - 1);
    // NEXT is itself an oRun-low cycle, so GAP lasts one cycle fewer than
    // GAP_CYC to make the total low time between windows equal GAP_CYC.
    localparam int unsigned GAP_ST   = (GAP_CYC > 1) ? GAP_CYC - 1 : 1;
    localparam logic [3:0]  GAP_LAST = 4'(GAP_ST - 1);

    state_t      r_state, w_state_nxt;
    logic [8:0]  r_width, r_height, w_width, w_height;
    logic [2:0]  r_step, w_step;
    logic [13:0] r_timer, w_timer;
    logic [3:0]  r_gap, w_gap;

    logic        w_run, w_busy, w_face_valid, w_timeout_flag, w_err, w_done;
    logic [8:0]  w_x, w_y;
    logic [7:0]  w_face_count;
    logic [15:0] w_win_count;

    logic        w_start_ok, w_abort, w_tmo, w_fit_x, w_fit_y;

    assign w_start_ok = ({1'b0, iImg_width} >= WIN10) && ({1'b0, iImg_height} >= WIN10)
                        && (iStep != 3'd0);
    assign w_abort    = iAbort && (r_state != S_IDLE);
    assign w_tmo      = (r_timer == TMO_LAST);
    // 10-bit sums: 511 + 7 + WIN cannot wrap.
    assign w_fit_x    = ({1'b0, oWin_x} + {7'd0, r_step} + WIN10) <= {1'b0, r_width};
    assign w_fit_y    = ({1'b0, oWin_y} + {7'd0, r_step} + WIN10) <= {1'b0, r_height};

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_step      <= '0;
            r_timer     <= '0;
            r_gap       <= '0;
            oRun        <= 1'b0;
            oBusy       <= 1'b0;
            oFace_valid <= 1'b0;
            oTimeout    <= 1'b0;
            oErr        <= 1'b0;
            oDone       <= 1'b0;
            oWin_x      <= '0;
            oWin_y      <= '0;
            oFace_count <= '0;
            oWin_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_width     <= w_width;
            r_height    <= w_height;
            r_step      <= w_step;
            r_timer     <= w_timer;
            r_gap       <= w_gap;
            oRun        <= w_run;
            oBusy       <= w_busy;
            oFace_valid <= w_face_valid;
            oTimeout    <= w_timeout_flag;
            oErr        <= w_err;
            oDone       <= w_done;
            oWin_x      <= w_x;
            oWin_y      <= w_y;
            oFace_count <= w_face_count;
            oWin_count  <= w_win_count;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (iStart && w_start_ok) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = S_RUN;
                S_RUN:   if (iWin_done || w_tmo) w_state_nxt = S_GAP;
                S_GAP:   if (r_gap == GAP_LAST) w_state_nxt = S_NEXT;
                S_NEXT:  w_state_nxt = (w_fit_x || w_fit_y) ? S_RUN : S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_width        = r_width;
        w_height       = r_height;
        w_step         = r_step;
        w_timer        = r_timer;
        w_gap          = r_gap;
        w_run          = oRun;
        w_busy         = (w_state_nxt != S_IDLE);
        w_face_valid   = 1'b0;
        w_timeout_flag = oTimeout;
        w_err          = 1'b0;
        w_done         = 1'b0;
        w_x            = oWin_x;
        w_y            = oWin_y;
        w_face_count   = oFace_count;
        w_win_count    = oWin_count;
        if (w_abort) begin
            w_run = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        if (w_start_ok) begin
                            w_width        = iImg_width;
                            w_height       = iImg_height;
                            w_step         = iStep;
                            w_x            = '0;
                            w_y            = '0;
                            w_face_count   = '0;
                            w_win_count    = '0;
                            w_timeout_flag = 1'b0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    w_run   = 1'b1;
                    w_timer = '0;
                end
                S_RUN: begin
                    w_timer = r_timer + 14'd1;
                    if (iWin_done) begin
                        w_run       = 1'b0;
                        w_gap       = '0;
                        w_win_count = oWin_count + 16'd1;
                        if (iWin_face) begin
                            w_face_valid = 1'b1;
                            if (oFace_count != 8'hFF) w_face_count = oFace_count + 8'd1;
                        end
                    end else if (w_tmo) begin
                        w_run          = 1'b0;
                        w_gap          = '0;
                        w_timeout_flag = 1'b1;
                        w_win_count    = oWin_count + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap != GAP_LAST) w_gap = r_gap + 4'd1;
                end
                S_NEXT: begin
                    w_timer = '0;
                    if (w_fit_x) begin
                        w_x   = oWin_x + {6'd0, r_step};
                        w_run = 1'b1;
                    end else if (w_fit_y) begin
                        w_x   = '0;
                        w_y   = oWin_y + {6'd0, r_step};
                        w_run = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hfg_window_scheduler.sv
module tb_hfg_window_scheduler;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic        iStart, iAbort, iWin_done, iWin_face;
    logic [8:0]  iImg_width, iImg_height;
    logic [2:0]  iStep;
    logic        oRun, oBusy, oFace_valid, oTimeout, oErr, oDone;
    logic [8:0]  oWin_x, oWin_y;
    logic [7:0]  oFace_count;
    logic [15:0] oWin_count;

    int checks   = 0;
    int failures = 0;

    always #5 iClk = ~iClk;

    hfg_window_scheduler #(.WIN(19), .GAP_CYC(2), .TIMEOUT_CYC(16)) dut (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .iStart      (iStart),
        .iAbort      (iAbort),
        .iImg_width  (iImg_width),
        .iImg_height (iImg_height),
        .iStep       (iStep),
        .iWin_done   (iWin_done),
        .iWin_face   (iWin_face),
        .oRun        (oRun),
        .oWin_x      (oWin_x),
        .oWin_y      (oWin_y),
        .oBusy       (oBusy),
        .oFace_valid (oFace_valid),
        .oFace_count (oFace_count),
        .oWin_count  (oWin_count),
        .oTimeout    (oTimeout),
        .oErr        (oErr),
        .oDone       (oDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (oRun !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk(tag, 32'(oRun), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (oDone !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(oDone), 1);
    endtask

    task automatic start_scan(input logic [8:0] w, input logic [8:0] h, input logic [2:0] s);
        iImg_width  = w;
        iImg_height = h;
        iStep       = s;
        iStart      = 1'b1;
        tick();
        iStart      = 1'b0;
    endtask

    // Finish the current window with a verdict after `cyc` cycles of oRun high.
    task automatic finish_window(input int cyc, input logic face);
        repeat (cyc - 1) tick();
        iWin_done = 1'b1;
        iWin_face = face;
        tick();
        iWin_done = 1'b0;
        iWin_face = 1'b0;
    endtask

    initial begin
        int ex[6] = '{0, 2, 4, 0, 2, 4};
        int ey[6] = '{0, 0, 0, 2, 2, 2};
        int cnt;
        iReset_n = 1'b0;
        iStart = 1'b0; iAbort = 1'b0; iWin_done = 1'b0; iWin_face = 1'b0;
        iImg_width = '0; iImg_height = '0; iStep = '0;
        #1;
        chk("rst_run", 32'(oRun), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_wcnt", 32'(oWin_count), 0);
        chk("rst_fcnt", 32'(oFace_count), 0);
        chk("rst_xy", {oWin_x, oWin_y}, 0);
        repeat (2) tick();
        iReset_n = 1'b1;
        tick();

        // Rejected starts
        start_scan(9'd18, 9'd19, 3'd1);
        chk("err_w18_err", 32'(oErr), 1);
        chk("err_w18_busy", 32'(oBusy), 0);
        chk("err_w18_run", 32'(oRun), 0);
        tick();
        chk("err_pulse_end", 32'(oErr), 0);
        start_scan(9'd19, 9'd19, 3'd0);
        chk("err_step0_err", 32'(oErr), 1);
        chk("err_step0_busy", 32'(oBusy), 0);
        tick();

        // Single 19x19 window with a face
        start_scan(9'd19, 9'd19, 3'd1);
        chk("one_load_busy", 32'(oBusy), 1);
        chk("one_load_run", 32'(oRun), 0);
        tick();
        chk("one_run_rise", 32'(oRun), 1);
        finish_window(10, 1'b1);
        chk("one_fv", 32'(oFace_valid), 1);
        chk("one_run_fall", 32'(oRun), 0);
        chk("one_wcnt", 32'(oWin_count), 1);
        chk("one_fcnt", 32'(oFace_count), 1);
        chk("one_xy", {oWin_x, oWin_y}, 0);
        tick();
        chk("one_fv_pulse", 32'(oFace_valid), 0);
        wait_done("one_done");
        tick();
        chk("one_done_pulse", 32'(oDone), 0);
        chk("one_idle", 32'(oBusy), 0);
        chk("one_wcnt_hold", 32'(oWin_count), 1);

        // 23x21 step 2 raster; config inputs scrambled after the start
        start_scan(9'd23, 9'd21, 3'd2);
        iImg_width = 9'd19; iImg_height = 9'd19; iStep = 3'd7;
        for (int w = 0; w < 6; w++) begin
            wait_run("ras_run");
            chk("ras_x", 32'(oWin_x), 32'(ex[w]));
            chk("ras_y", 32'(oWin_y), 32'(ey[w]));
            finish_window(5, 1'b0);
            chk("ras_run_fall", 32'(oRun), 0);
            if (w < 5) begin
                cnt = 0;
                while (oRun !== 1'b1 && cnt < 20) begin
                    cnt++;
                    tick();
                end
                chk("ras_gap_len", 32'(cnt), 2);
            end
        end
        wait_done("ras_done");
        chk("ras_wcnt", 32'(oWin_count), 6);
        chk("ras_fcnt", 32'(oFace_count), 0);
        chk("ras_tmo", 32'(oTimeout), 0);
        tick();

        // Timeout after 16 RUN cycles
        start_scan(9'd19, 9'd19, 3'd1);
        tick();
        cnt = 0;
        while (oRun === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("tmo_run_len", 32'(cnt), 16);
        chk("tmo_flag", 32'(oTimeout), 1);
        chk("tmo_wcnt", 32'(oWin_count), 1);
        wait_done("tmo_done");
        tick();
        chk("tmo_sticky", 32'(oTimeout), 1);

        // Done on the last timer cycle beats the timeout
        start_scan(9'd19, 9'd19, 3'd1);
        chk("tmo_clr_on_start", 32'(oTimeout), 0);
        tick();
        finish_window(16, 1'b1);
        chk("race_tmo", 32'(oTimeout), 0);
        chk("race_fv", 32'(oFace_valid), 1);
        chk("race_wcnt", 32'(oWin_count), 1);
        wait_done("race_done");
        tick();

        // Abort during the third window
        start_scan(9'd23, 9'd21, 3'd2);
        for (int w = 0; w < 2; w++) begin
            wait_run("abt_run");
            finish_window(5, 1'b0);
        end
        wait_run("abt_run3");
        chk("abt_x3", 32'(oWin_x), 4);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        chk("abt_run", 32'(oRun), 0);
        chk("abt_busy", 32'(oBusy), 0);
        chk("abt_wcnt", 32'(oWin_count), 2);
        cnt = 0;
        repeat (6) begin
            if (oDone === 1'b1) cnt++;
            tick();
        end
        chk("abt_no_done", 32'(cnt), 0);

        // iWin_done while idle is ignored
        iWin_done = 1'b1;
        tick();
        iWin_done = 1'b0;
        tick();
        chk("idle_done_ign", 32'(oWin_count), 2);

        // Asynchronous reset in the middle of the second window
        start_scan(9'd23, 9'd21, 3'd2);
        wait_run("ar_run1");
        finish_window(5, 1'b1);
        chk("ar_fcnt_pre", 32'(oFace_count), 1);
        wait_run("ar_run2");
        #3;
        iReset_n = 1'b0;
        #1;
        chk("ar_run", 32'(oRun), 0);
        chk("ar_busy", 32'(oBusy), 0);
        chk("ar_wcnt", 32'(oWin_count), 0);
        chk("ar_fcnt", 32'(oFace_count), 0);
        chk("ar_x", 32'(oWin_x), 0);
        tick();
        iReset_n = 1'b1;
        tick();
        chk("ar_stay_idle", 32'(oBusy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
